seq_divider: RTL and testbench

//   Sequential unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
//   - One trial subtraction per clock, through a shared add/sub unit in subtract mode.
//   - Inverse companion to the combinational 4-bit add/sub datapath.
//   - Sits after operand registers. Results are consumed by downstream logic on the done pulse.

---
 rtl/seq_divider_pkg.sv | 20 ++
 rtl/seq_divider_if.sv | 36 +++
 rtl/seq_divider_addsub.sv | 19 +
 rtl/seq_divider.sv | 144 ++++++++++++++
 tb/tb_seq_divider.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - DEF_WIDTH : default operand / quotient / remainder width
//   - state_e   : controller state encoding
//   - cnt_width : width of the iteration counter for a given operand width
package seq_divider_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the divider and its client.
//   start        client -> divider  request a division
//   dividend     client -> divider  numerator, captured on accepted start
//   divisor      client -> divider  denominator, captured on accepted start
//   busy         divider -> client  high while iterating
//   done         divider -> client  one-cycle result-valid pulse
//   quotient     divider -> client  result, held until next accepted start
//   remainder    divider -> client  result, held until next accepted start
//   div_by_zero  divider -> client  flagged with done when divisor was 0
// master = client side, slave = divider side.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_addsub.sv
// Generic W-bit adder/subtractor.
//   a, b  : operands
//   sub   : 1 = a - b (two's complement), 0 = a + b
//   s     : W-bit result
//   cout  : carry out; in subtract mode 1 means no borrow (a >= b)
module addsub_unit #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);

  // Inverting b and injecting sub as carry-in turns the adder into a subtractor.
  assign {cout, s} = {1'b0, a} + {1'b0, (b ^ {W{sub}})} + {{W{1'b0}}, sub};

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one trial subtraction per clock.
//   clk     : clock, all state changes on rising edge
//   rst     : synchronous active-high reset
//   bus_if  : slave side of seq_divider_if (start/operands in, results out)
// An accepted start captures the operands; WIDTH RUN cycles each shift the
// {P,Q} pair left and try P - D. The status/result outputs are registered
// from the controller state, so they trail the state by one edge.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus_if
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             dz_q, dz_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             no_borrow;

  // After a restoring step P < D fits in WIDTH bits, so its top bit never
  // feeds the next shift.
  logic             unused_p_msb;
  assign unused_p_msb = p_q[WIDTH];

  // Partial remainder shifted left with the next dividend bit pulled in.
  assign shifted = {p_q[WIDTH-1:0], q_q[WIDTH-1]};

  addsub_unit #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a    (shifted),
    .b    ({1'b0, d_q}),
    .sub  (1'b1),
    .s    (trial),
    .cout (no_borrow)
  );

  // Controller and datapath next-state: accept requests in IDLE/DONE, run
  // one restoring step per RUN cycle, and publish results when leaving DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    dz_d    = dz_q;
    busy_d  = (state_q == RUN);
    done_d  = (state_q == DONE);
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    if (state_q == DONE) begin
      quot_d = q_q;
      rem_d  = p_q[WIDTH-1:0];
      dbz_d  = dz_q;
    end

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus_if.start) begin
          d_d   = bus_if.divisor;
          cnt_d = '0;
          if (bus_if.divisor == '0) begin
            dz_d    = 1'b1;
            q_d     = '1;
            p_d     = {1'b0, bus_if.dividend};
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            q_d     = bus_if.dividend;
            p_d     = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d   = no_borrow ? trial : shifted;
        q_d   = {q_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus_if.busy        = busy_q;
  assign bus_if.done        = done_q;
  assign bus_if.quotient    = quot_q;
  assign bus_if.remainder   = rem_q;
  assign bus_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4). Expected results are pushed
// into a scoreboard queue when a request is issued and popped when done rises.
module tb_seq_divider;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(W)) dif ();

  seq_divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (dif)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model for one request, kept independent of the restoring algorithm.
  task automatic pushExpect(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e = {4'hF, a, 1'b1};
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic popExpect(output exp_t e);
    if (sb.size() == 0) e = 'x;
    else e = sb.pop_front();
  endtask

  // Drive a one-cycle start; returns at the negedge just after the accepting edge.
  task automatic issueStart(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    pushExpect(a, b);
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = ~a;
    dif.divisor  = ~b;
  endtask

  // Wait (bounded) until done is seen; counts edges and busy cycles on the way.
  task automatic waitDone(output int edges, output int busyCyc, output bit timedOut);
    edges    = 0;
    busyCyc  = 0;
    timedOut = 1'b0;
    while (dif.done !== 1'b1) begin
      if (dif.busy === 1'b1) busyCyc++;
      if (edges >= 50) begin
        timedOut = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
  endtask

  function automatic exp_t observed();
    return {dif.quotient, dif.remainder, dif.div_by_zero};
  endfunction

  task automatic test_reset();
    logic [2*W+2:0] outs;
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(negedge clk);
    outs = {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero};
    compared++;
    if (outs !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b, expected all zero", outs);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int edges, busyCyc;
    bit to;
    exp_t e, got;
    issueStart(4'd9, 4'd2);
    waitDone(edges, busyCyc, to);
    compared++;
    if (to || edges != W + 1) begin
      mismatched++;
      $display("[TB] FAIL basic_latency: got %0d edges (timeout=%0b), expected %0d", edges, to, W + 1);
    end
    compared++;
    if (busyCyc != W) begin
      mismatched++;
      $display("[TB] FAIL basic_busy: got %0d busy cycles, expected %0d", busyCyc, W);
    end
    popExpect(e);
    got = observed();
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("[TB] FAIL basic_result: got q=%0d r=%0d dz=%0b, expected q=%0d r=%0d dz=%0b", got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
    @(negedge clk);
    compared++;
    if (dif.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_done_pulse: got done=%b one cycle later, expected 0", dif.done);
    end
    repeat (3) @(negedge clk);
    got = observed();
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("[TB] FAIL basic_hold: got q=%0d r=%0d, expected q=%0d r=%0d held", got.q, got.r, e.q, e.r);
    end
  endtask

  task automatic test_equal_small();
    int edges, busyCyc;
    bit to;
    exp_t e, got;
    logic [W-1:0] aList [2];
    logic [W-1:0] bList [2];
    aList[0] = 4'd15; bList[0] = 4'd15;
    aList[1] = 4'd3;  bList[1] = 4'd9;
    for (int i = 0; i < 2; i++) begin
      issueStart(aList[i], bList[i]);
      waitDone(edges, busyCyc, to);
      compared++;
      if (to || busyCyc != W) begin
        mismatched++;
        $display("[TB] FAIL equal_small_busy[%0d]: got %0d busy cycles (timeout=%0b), expected %0d", i, busyCyc, to, W);
      end
      popExpect(e);
      got = observed();
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("[TB] FAIL equal_small_result[%0d]: got q=%0d r=%0d dz=%0b, expected q=%0d r=%0d dz=%0b", i, got.q, got.r, got.dz, e.q, e.r, e.dz);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int edges, busyCyc;
    bit to;
    exp_t e, got;
    issueStart(4'd7, 4'd0);
    waitDone(edges, busyCyc, to);
    compared++;
    if (to || edges != 1) begin
      mismatched++;
      $display("[TB] FAIL dbz_latency: got %0d edges after accept (timeout=%0b), expected 1", edges, to);
    end
    compared++;
    if (busyCyc != 0) begin
      mismatched++;
      $display("[TB] FAIL dbz_busy: got %0d busy cycles, expected 0", busyCyc);
    end
    popExpect(e);
    got = observed();
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("[TB] FAIL dbz_result: got q=%0d r=%0d dz=%0b, expected q=%0d r=%0d dz=%0b", got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_start_while_busy();
    int edges, busyCyc;
    bit to;
    exp_t e, got;
    issueStart(4'd12, 4'd5);
    repeat (2) @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 4'd1;
    dif.divisor  = 4'd1;
    @(negedge clk);
    dif.start    = 1'b0;
    waitDone(edges, busyCyc, to);
    compared++;
    if (to || edges + 3 != W + 1) begin
      mismatched++;
      $display("[TB] FAIL busy_start_latency: got %0d edges (timeout=%0b), expected %0d", edges + 3, to, W + 1);
    end
    popExpect(e);
    got = observed();
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("[TB] FAIL busy_start_result: got q=%0d r=%0d dz=%0b, expected q=%0d r=%0d dz=%0b", got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
    repeat (W + 3) @(negedge clk);
    compared++;
    if (observed() !== e) begin
      mismatched++;
      $display("[TB] FAIL busy_start_ignored: got q=%0d r=%0d later, expected q=%0d r=%0d", dif.quotient, dif.remainder, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back();
    int edges, busyCyc;
    bit to;
    exp_t e, got;
    issueStart(4'd14, 4'd3);
    waitDone(edges, busyCyc, to);
    popExpect(e);
    got = observed();
    compared++;
    if (to || got !== e) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got q=%0d r=%0d dz=%0b (timeout=%0b), expected q=%0d r=%0d dz=%0b", got.q, got.r, got.dz, to, e.q, e.r, e.dz);
    end
    dif.start    = 1'b1;
    dif.dividend = 4'd8;
    dif.divisor  = 4'd8;
    pushExpect(4'd8, 4'd8);
    @(negedge clk);
    dif.start = 1'b0;
    compared++;
    if (dif.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_done_pulse: got done=%b, expected 0", dif.done);
    end
    waitDone(edges, busyCyc, to);
    compared++;
    if (to || edges != W + 1) begin
      mismatched++;
      $display("[TB] FAIL b2b_latency: got %0d edges (timeout=%0b), expected %0d", edges, to, W + 1);
    end
    popExpect(e);
    got = observed();
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got q=%0d r=%0d dz=%0b, expected q=%0d r=%0d dz=%0b", got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_reset_mid_op();
    int edges, busyCyc, doneSeen;
    bit to;
    exp_t e, got;
    logic [2*W+2:0] outs;
    issueStart(4'd13, 4'd4);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    outs = {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero};
    compared++;
    if (outs !== '0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_outputs: got %b, expected all zero", outs);
    end
    rst = 1'b0;
    void'(sb.pop_back());
    doneSeen = 0;
    repeat (2 * W + 2) begin
      @(negedge clk);
      if (dif.done === 1'b1 || dif.busy === 1'b1) doneSeen++;
    end
    compared++;
    if (doneSeen != 0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_abandon: got %0d busy/done cycles after reset, expected 0", doneSeen);
    end
    issueStart(4'd13, 4'd4);
    waitDone(edges, busyCyc, to);
    popExpect(e);
    got = observed();
    compared++;
    if (to || got !== e) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_restart: got q=%0d r=%0d dz=%0b (timeout=%0b), expected q=%0d r=%0d dz=%0b", got.q, got.r, got.dz, to, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_sweep();
    int edges, busyCyc, expEdges;
    bit to;
    exp_t e, got;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issueStart(4'(a), 4'(b));
        waitDone(edges, busyCyc, to);
        expEdges = (b == 0) ? 1 : W + 1;
        popExpect(e);
        got = observed();
        compared++;
        if (to || edges != expEdges || got !== e) begin
          mismatched++;
          $display("[TB] FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%0b after %0d edges, expected q=%0d r=%0d dz=%0b after %0d", a, b, got.q, got.r, got.dz, edges, e.q, e.r, e.dz, expEdges);
        end
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_equal_small();
    test_div_by_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
